// File: rtl/prog_mem.sv
// Program memory for a small CPU: 16x8 instruction store, loaded byte-by-byte
// over a ready/valid stream, holding the CPU in reset until a full program is in.
module prog_mem #(
  parameter logic [7:0] NOP_ORDER = 8'b00000000,
  parameter int         LOAD_LEN  = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] CNT,
  output logic [7:0] order,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       load_done,
  output logic       cpu_hold,
  output logic [4:0] wcount
);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(LOAD_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] mem [16];
  logic [3:0] ptr;
  logic       accept, last;

  // load_start wins over a byte offered in the same cycle
  assign accept = load_valid & load_ready & ~load_start;
  assign last   = accept & (ptr == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cpu_hold   = 1'b1;
    order      = NOP_ORDER;
    case (state)
      LOAD: load_ready = 1'b1;
      RUN: begin
        cpu_hold = 1'b0;
        order    = mem[CNT];
      end
      default: ;
    endcase
    if (load_start) state_nxt = LOAD;
    else if (last)  state_nxt = RUN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= NOP_ORDER;
      ptr       <= '0;
      wcount    <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= last;
      if (load_start) begin
        for (int i = 0; i < 16; i++) mem[i] <= NOP_ORDER;
        ptr    <= '0;
        wcount <= '0;
      end else if (accept) begin
        mem[ptr] <= load_data;
        wcount   <= wcount + 5'd1;
        // pointer parks on the last index so a finished load never wraps
        if (!last) ptr <= ptr + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a full-length and a 3-byte instance share one stimulus
// stream and are checked each cycle against a program-level model.
module tb_prog_mem;

  localparam int LEN [2] = '{16, 3};

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt = '0;
  logic       ls = 1'b0, lv = 1'b0;
  logic [7:0] ld = '0;

  logic [7:0] order_o [2];
  logic       ready_o [2];
  logic       done_o  [2];
  logic       hold_o  [2];
  logic [4:0] wcnt_o  [2];

  prog_mem #(.NOP_ORDER(8'h00), .LOAD_LEN(16)) dut (
    .CLK(CLK), .RST(rst), .CNT(cnt), .order(order_o[0]),
    .load_start(ls), .load_valid(lv), .load_data(ld),
    .load_ready(ready_o[0]), .load_done(done_o[0]), .cpu_hold(hold_o[0]), .wcount(wcnt_o[0]));

  prog_mem #(.NOP_ORDER(8'h00), .LOAD_LEN(3)) dut3 (
    .CLK(CLK), .RST(rst), .CNT(cnt), .order(order_o[1]),
    .load_start(ls), .load_valid(lv), .load_data(ld),
    .load_ready(ready_o[1]), .load_done(done_o[1]), .cpu_hold(hold_o[1]), .wcount(wcnt_o[1]));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // model: phase 0 = no program, 1 = loading, 2 = running
  int       ph    [2];
  int       mcnt  [2];
  bit       mdone [2];
  bit [7:0] prog  [2][16];

  always @(posedge CLK or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] = 0; mcnt[i] = 0; mdone[i] = 0;
        for (int j = 0; j < 16; j++) prog[i][j] = 8'h00;
      end else begin
        mdone[i] = 0;
        if (ls) begin
          ph[i] = 1; mcnt[i] = 0;
          for (int j = 0; j < 16; j++) prog[i][j] = 8'h00;
        end else if (ph[i] == 1 && lv) begin
          prog[i][mcnt[i]] = ld;
          mcnt[i]++;
          if (mcnt[i] == LEN[i]) begin ph[i] = 2; mdone[i] = 1; end
        end
      end
    end
  end

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        cmp("order",  i, 32'(order_o[i]), 32'((ph[i] == 2) ? prog[i][cnt] : 8'h00));
        cmp("ready",  i, 32'(ready_o[i]), 32'(ph[i] == 1));
        cmp("hold",   i, 32'(hold_o[i]),  32'(ph[i] != 2));
        cmp("done",   i, 32'(done_o[i]),  32'(mdone[i]));
        cmp("wcount", i, 32'(wcnt_o[i]),  32'(mcnt[i]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load();
    ls = 1'b1; lv = 1'b0; tick();
    ls = 1'b0;
  endtask

  logic [7:0] bytes [16];

  initial begin
    tick();
    rst = 1'b0;
    chk_on = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    // reset / idle state, several fetch addresses
    for (int c = 0; c < 16; c += 5) begin
      cnt = 4'(c); #1;
      for (int i = 0; i < 2; i++) begin
        cmp("idle_hold", i, 32'(hold_o[i]), 1);
        cmp("idle_ready", i, 32'(ready_o[i]), 0);
        cmp("idle_order", i, 32'(order_o[i]), 32'h00);
      end
    end

    // full 16-byte load with load_valid held
    start_load();
    cmp("load_ready", 0, 32'(ready_o[0]), 1);
    for (int k = 0; k < 16; k++) begin
      lv = 1'b1; ld = 8'(8'hB1 + k); tick();
    end
    cmp("done_pulse", 0, 32'(done_o[0]), 1);
    cmp("wcount16", 0, 32'(wcnt_o[0]), 16);
    cmp("run_hold", 0, 32'(hold_o[0]), 0);
    lv = 1'b0; tick();
    cmp("done_1cyc", 0, 32'(done_o[0]), 0);
    cnt = 4'd0; #1 cmp("fetch0", 0, 32'(order_o[0]), 32'hB1);
    cnt = 4'd15; #1 cmp("fetch15", 0, 32'(order_o[0]), 32'hC0);
    cnt = 4'd2; #1 cmp("len3_fetch2", 1, 32'(order_o[1]), 32'hB3);
    cnt = 4'd3; #1 cmp("len3_fetch3", 1, 32'(order_o[1]), 32'h00);

    // 3-byte load with load_valid toggling
    start_load();
    bytes[0] = 8'hB1; bytes[1] = 8'h01; bytes[2] = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      lv = 1'b1; ld = bytes[k]; tick();
      lv = 1'b0; ld = 8'hEE; tick();
    end
    cmp("len3_wcount", 1, 32'(wcnt_o[1]), 3);
    cmp("len3_hold", 1, 32'(hold_o[1]), 0);
    cnt = 4'd0; #1 cmp("len3_e0", 1, 32'(order_o[1]), 32'hB1);
    cnt = 4'd1; #1 cmp("len3_e1", 1, 32'(order_o[1]), 32'h01);
    cnt = 4'd2; #1 cmp("len3_e2", 1, 32'(order_o[1]), 32'hF0);
    for (int c = 3; c < 16; c++) begin
      cnt = 4'(c); #1 cmp("len3_nop", c, 32'(order_o[1]), 32'h00);
    end
    cmp("len16_partial", 0, 32'(wcnt_o[0]), 3);

    // restart together with the 5th byte
    start_load();
    for (int k = 0; k < 4; k++) begin
      lv = 1'b1; ld = 8'(8'h50 + k); tick();
    end
    ls = 1'b1; lv = 1'b1; ld = 8'hAA; tick();
    ls = 1'b0;
    cmp("restart_wcount", 0, 32'(wcnt_o[0]), 0);
    cmp("restart_ready", 0, 32'(ready_o[0]), 1);
    for (int k = 0; k < 16; k++) begin
      bytes[k] = 8'($urandom);
      lv = 1'b1; ld = bytes[k]; tick();
    end
    lv = 1'b0;
    cmp("reload_wcount", 0, 32'(wcnt_o[0]), 16);
    cnt = 4'd0; #1 cmp("reload_e0", 0, 32'(order_o[0]), 32'(bytes[0]));
    cnt = 4'd4; #1 cmp("reload_e4", 0, 32'(order_o[0]), 32'(bytes[4]));

    // load_start while running
    cnt = 4'd0;
    start_load();
    for (int i = 0; i < 2; i++) begin
      cmp("rerun_hold", i, 32'(hold_o[i]), 1);
      cmp("rerun_ready", i, 32'(ready_o[i]), 1);
      cmp("rerun_order", i, 32'(order_o[i]), 32'h00);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      ls  = ($urandom_range(0, 39) == 0);
      lv  = ($urandom_range(0, 9) < 7);
      ld  = 8'($urandom);
      cnt = 4'($urandom);
      tick();
    end
    rst = 1'b0; ls = 1'b0; lv = 1'b0; tick();

    // asynchronous reset mid-cycle while running
    start_load();
    for (int k = 0; k < 16; k++) begin
      lv = 1'b1; ld = 8'(8'h11 * k + 1); tick();
    end
    lv = 1'b0;
    cnt = 4'd3;
    cmp("pre_rst_hold", 0, 32'(hold_o[0]), 0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp("rst_hold", i, 32'(hold_o[i]), 1);
      cmp("rst_order", i, 32'(order_o[i]), 32'h00);
      cmp("rst_wcount", i, 32'(wcnt_o[i]), 0);
      cmp("rst_done", i, 32'(done_o[i]), 0);
    end
    tick(); tick();
    rst = 1'b0;
    lv = 1'b1; ld = 8'h77; tick(); tick();
    lv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmp("post_rst_ready", i, 32'(ready_o[i]), 0);
      cmp("post_rst_wcount", i, 32'(wcnt_o[i]), 0);
    end
    tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
